// File: rtl/gamma_seq_pkg.sv
// Shared types and constants for the gamma sequencer and its brightness scaler.
package gamma_seq_pkg;

    localparam int unsigned CH_W      = 8;
    localparam int unsigned OUT_W     = 12;
    localparam int unsigned PIX_IN_W  = 3 * CH_W;
    localparam int unsigned PIX_OUT_W = 3 * OUT_W;

    localparam int unsigned R_IN_LSB  = 2 * CH_W;
    localparam int unsigned G_IN_LSB  = CH_W;
    localparam int unsigned B_IN_LSB  = 0;
    localparam int unsigned R_OUT_LSB = 2 * OUT_W;
    localparam int unsigned G_OUT_LSB = OUT_W;
    localparam int unsigned B_OUT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_R,
        ST_G,
        ST_B,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/gamma_sequencer_scale.sv
// Combinational brightness scaler: (value * (scale + 1)) >> 8, truncated to OUT_W.
module gamma_scale
    import gamma_seq_pkg::*;
(
    input  logic [OUT_W-1:0] value,
    input  logic [CH_W-1:0]  scale,
    output logic [OUT_W-1:0] scaled
);

    logic [OUT_W+CH_W:0] product;

    // scale+1 needs the ninth bit so that 8'hff becomes an exact identity
    assign product = (OUT_W+CH_W+1)'(value) * (OUT_W+CH_W+1)'({1'b0, scale} + 9'd1);
    assign scaled  = OUT_W'(product >> CH_W);

endmodule

// File: rtl/gamma_sequencer.sv
// Time-multiplexes one shared gamma LUT over R, G, B of each input pixel.
// Optional global brightness scaling is enabled with GAMMA_BRIGHTNESS_EN.
module gamma_sequencer
    import gamma_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_IN_W-1:0]  in_rgb,
    input  logic                 in_sof,
    input  logic                 in_eol,
    output logic [CH_W-1:0]      lut_in,
    input  logic [OUT_W-1:0]     lut_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIX_OUT_W-1:0] out_rgb,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 busy
`ifdef GAMMA_BRIGHTNESS_EN
    ,
    input  logic [CH_W-1:0]      brightness
`endif
);

    state_t                state;
    state_t                next_state;
    logic                  accept;
    logic [PIX_IN_W-1:0]   pix_rgb;
    logic                  pix_sof;
    logic                  pix_eol;
    logic [OUT_W-1:0]      cap_val;

`ifdef GAMMA_BRIGHTNESS_EN
    logic [CH_W-1:0] pix_bright;

    gamma_scale u_scale (
        .value  (lut_out),
        .scale  (pix_bright),
        .scaled (cap_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_bright <= '0;
        end else if (accept) begin
            pix_bright <= brightness;
        end
    end
`else
    assign cap_val = lut_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        lut_in     = '0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid) next_state = ST_R;
            end
            ST_R: begin
                busy       = 1'b1;
                lut_in     = pix_rgb[R_IN_LSB +: CH_W];
                next_state = ST_G;
            end
            ST_G: begin
                busy       = 1'b1;
                lut_in     = pix_rgb[G_IN_LSB +: CH_W];
                next_state = ST_B;
            end
            ST_B: begin
                busy       = 1'b1;
                lut_in     = pix_rgb[B_IN_LSB +: CH_W];
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = rst_n & out_ready;
                // HOLD doubles as the next accept cycle when downstream takes the beat
                if (out_ready) next_state = in_valid ? ST_R : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        accept = in_valid & in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_rgb <= '0;
            pix_sof <= 1'b0;
            pix_eol <= 1'b0;
        end else if (accept) begin
            pix_rgb <= in_rgb;
            pix_sof <= in_sof;
            pix_eol <= in_eol;
        end
    end

    // Output channels are only written in R/G/B, so they stay frozen through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rgb <= '0;
            out_sof <= 1'b0;
            out_eol <= 1'b0;
        end else begin
            case (state)
                ST_R: out_rgb[R_OUT_LSB +: OUT_W] <= cap_val;
                ST_G: out_rgb[G_OUT_LSB +: OUT_W] <= cap_val;
                ST_B: begin
                    out_rgb[B_OUT_LSB +: OUT_W] <= cap_val;
                    out_sof <= pix_sof;
                    out_eol <= pix_eol;
                end
                default: ;
            endcase
        end
    end

endmodule
